// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access; one transaction in flight.
// Data normally wins, but a bounded run of data grants lets a waiting fetch through.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W/8-1:0] inst_wstrb,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stallreq_for_mem
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    logic [1:0]       state;
    logic             owner;
    logic [CNT_W-1:0] starve_cnt;

    logic starve_hit;
    logic grant_inst;
    logic grant_data;
    logic addr_accept;
    logic resp_valid;
    logic in_wait;
    logic inst_pending;
    logic data_pending;

    assign starve_hit = (starve_cnt == CNT_MAX);
    assign grant_inst = inst_req & (~data_req | starve_hit);
    assign grant_data = data_req & ~grant_inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            starve_cnt <= '0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_inst | grant_data) begin
                        state <= ADDR;
                        owner <= grant_data ? OWN_DATA : OWN_INST;
                        if (grant_data) begin
                            mem_wr    <= data_wr;
                            mem_addr  <= data_addr;
                            mem_wstrb <= data_wstrb;
                            mem_wdata <= data_wdata;
                        end else begin
                            mem_wr    <= inst_wr;
                            mem_addr  <= inst_addr;
                            mem_wstrb <= inst_wstrb;
                            mem_wdata <= inst_wdata;
                        end
                        // Only data grants that bypass a waiting fetch count toward starvation.
                        if (grant_data & inst_req) begin
                            if (!starve_hit) begin
                                starve_cnt <= starve_cnt + CNT_W'(1);
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (mem_addr_ok) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req     = (state == ADDR);
    assign addr_accept = (state == ADDR) & mem_addr_ok;
    assign in_wait     = (state == WAIT);
    assign resp_valid  = in_wait & mem_data_ok;

    assign inst_addr_ok = addr_accept & (owner == OWN_INST);
    assign data_addr_ok = addr_accept & (owner == OWN_DATA);
    assign inst_data_ok = resp_valid & (owner == OWN_INST);
    assign data_data_ok = resp_valid & (owner == OWN_DATA);
    assign inst_rdata   = (in_wait && owner == OWN_INST) ? mem_rdata : '0;
    assign data_rdata   = (in_wait && owner == OWN_DATA) ? mem_rdata : '0;

    assign inst_pending = (state != IDLE) & (owner == OWN_INST);
    assign data_pending = (state != IDLE) & (owner == OWN_DATA);

    assign stallreq_for_mem = ((inst_req | inst_pending) & ~inst_data_ok)
                            | ((data_req | data_pending) & ~data_data_ok);

endmodule
